lcb_rx_frame: RTL

- Serial byte receiver and frame tracker feeding lcbFull; directly upstream of it.
- Deserialises the LCB telemetry line (8N1, LSB first) into bytes and presents each on rawData/rxValid in the form lcbFull consumes.
- Tracks position inside the 15-byte LCB frame and drops partial frames on line gaps or framing errors.
- Pulses resync so the downstream byte counter can realign.

---
 rtl/lcb_rx_frame_pkg.sv | 26 ++
 rtl/lcb_rx_frame_sync.sv | 31 +++
 rtl/lcb_rx_frame.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcb_rx_frame_pkg.sv
// Shared constants for the LCB serial receiver: FSM state encoding,
// default timing parameters, error counter ceiling and a parity helper.
package lcb_rx_pkg;

   localparam int BIT_CYCLES_DEF  = 32;
   localparam int FRAME_BYTES_DEF = 15;
   localparam int VALID_HOLD_DEF  = 4;
   localparam int GAP_TIMEOUT_DEF = 640;

   localparam logic [7:0] ERRCNT_MAX = 8'hFF;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   typedef logic [7:0] lcb_byte_t;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input lcb_byte_t b);
      return ^b;
   endfunction

endpackage

// File: rtl/lcb_rx_frame_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge
// detect. Flops reset to 1 so a released reset never looks like a start edge.
module lcb_rx_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic rx_i,
   output logic rx_sync_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronise the line and keep one cycle of history for edge detection.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_sync_o = sync_q;
   assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/lcb_rx_frame.sv
// LCB telemetry line receiver: deserialises 8N1 bytes (8E1 when
// LCB_RX_PARITY_EN is defined), tracks the position inside the LCB frame,
// and reports framing errors / inter-byte gap timeouts as frameErr+resync.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a start edge; gap timer runs here
// START     | waiting for mid start bit; high sample means a glitch
// DATA      | sampling 8 data bits, LSB first, one bit period apart
// PARITY    | sampling the even parity bit (LCB_RX_PARITY_EN only)
// STOP      | sampling the stop bit; 1 accepts the byte, 0 is an error
// WAIT_HIGH | after an error, hold off until the line returns high
module lcb_rx_frame
   import lcb_rx_pkg::*;
#(
   parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
   parameter int FRAME_BYTES = FRAME_BYTES_DEF,
   parameter int VALID_HOLD  = VALID_HOLD_DEF,
   parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_i,
   output logic [7:0] rawData_o,
   output logic       rxValid_o,
   output logic [3:0] byteIdx_o,
   output logic       frameDone_o,
   output logic       frameErr_o,
   output logic       resync_o,
   output logic [7:0] errCnt_o
);

   localparam int BCW = $clog2(BIT_CYCLES);
   localparam int HW  = $clog2(VALID_HOLD + 1);
   localparam int GW  = $clog2(GAP_TIMEOUT + 1);

   localparam logic [BCW-1:0] BIT_HALF = BCW'(BIT_CYCLES / 2);
   localparam logic [BCW-1:0] BIT_FULL = BCW'(BIT_CYCLES - 1);
   localparam logic [3:0]     POS_LAST = 4'(FRAME_BYTES - 1);

   logic rx_s;
   logic rx_fall;

   logic [2:0]     state_q,    state_d;
   logic [BCW-1:0] bit_cnt_q,  bit_cnt_d;
   logic [2:0]     data_cnt_q, data_cnt_d;
   lcb_byte_t      shift_q,    shift_d;
   lcb_byte_t      raw_q,      raw_d;
   logic           valid_q,    valid_d;
   logic [HW-1:0]  hold_q,     hold_d;
   logic [3:0]     idx_q,      idx_d;
   logic [3:0]     pos_q,      pos_d;
   logic           done_q,     done_d;
   logic           err_q,      err_d;
   logic [7:0]     errcnt_q,   errcnt_d;
   logic [GW-1:0]  gap_q,      gap_d;
   logic           gap_run_q,  gap_run_d;

   logic accept;
   logic fail;

   lcb_rx_sync u_sync (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .rx_i      (rx_i),
      .rx_sync_o (rx_s),
      .fall_o    (rx_fall)
   );

   // Bit-level FSM, rxValid hold timer, gap timer and frame position.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      data_cnt_d = data_cnt_q;
      shift_d    = shift_q;
      raw_d      = raw_q;
      valid_d    = valid_q;
      hold_d     = hold_q;
      idx_d      = idx_q;
      pos_d      = pos_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      errcnt_d   = errcnt_q;
      gap_d      = gap_q;
      gap_run_d  = gap_run_q;
      accept     = 1'b0;
      fail       = 1'b0;

      // rxValid runs off its own timer so errors never cut it short.
      if (valid_q) begin
         if (hold_q == '0) begin
            valid_d = 1'b0;
         end else begin
            hold_d = hold_q - HW'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               state_d   = ST_START;
               bit_cnt_d = BIT_HALF;
            end
         end
         ST_START: begin
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end else if (!rx_s) begin
               state_d    = ST_DATA;
               bit_cnt_d  = BIT_FULL;
               data_cnt_d = 3'd7;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end else begin
               shift_d   = {rx_s, shift_q[7:1]};
               bit_cnt_d = BIT_FULL;
               if (data_cnt_q == 3'd0) begin
`ifdef LCB_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  data_cnt_d = data_cnt_q - 3'd1;
               end
            end
         end
`ifdef LCB_RX_PARITY_EN
         ST_PARITY: begin
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end else if (rx_s == even_parity(shift_q)) begin
               state_d   = ST_STOP;
               bit_cnt_d = BIT_FULL;
            end else begin
               fail    = 1'b1;
               state_d = ST_WAIT_HIGH;
            end
         end
`endif
         ST_STOP: begin
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end else if (rx_s) begin
               // Straight back to IDLE: a back-to-back start edge is only
               // half a bit away.
               accept  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               fail    = 1'b1;
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Gap timer: armed by each accepted byte, counts only while idle,
      // and fires once.
      if (state_q == ST_IDLE && gap_run_q) begin
         if (gap_q <= GW'(1)) begin
            gap_run_d = 1'b0;
            gap_d     = '0;
            if (pos_q != 4'd0) begin
               fail = 1'b1;
            end
         end else begin
            gap_d = gap_q - GW'(1);
         end
      end

      if (accept) begin
         raw_d     = shift_q;
         valid_d   = 1'b1;
         hold_d    = HW'(VALID_HOLD - 1);
         idx_d     = pos_q;
         gap_d     = GW'(GAP_TIMEOUT);
         gap_run_d = 1'b1;
         if (pos_q == POS_LAST) begin
            done_d = 1'b1;
            pos_d  = 4'd0;
         end else begin
            pos_d = pos_q + 4'd1;
         end
      end

      if (fail) begin
         err_d = 1'b1;
         pos_d = 4'd0;
         idx_d = 4'd0;
         if (errcnt_q != ERRCNT_MAX) begin
            errcnt_d = errcnt_q + 8'd1;
         end
      end
   end

   // State and output registers; reset mid-byte drops everything silently.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         data_cnt_q <= '0;
         shift_q    <= '0;
         raw_q      <= '0;
         valid_q    <= 1'b0;
         hold_q     <= '0;
         idx_q      <= '0;
         pos_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         errcnt_q   <= '0;
         gap_q      <= '0;
         gap_run_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         data_cnt_q <= data_cnt_d;
         shift_q    <= shift_d;
         raw_q      <= raw_d;
         valid_q    <= valid_d;
         hold_q     <= hold_d;
         idx_q      <= idx_d;
         pos_q      <= pos_d;
         done_q     <= done_d;
         err_q      <= err_d;
         errcnt_q   <= errcnt_d;
         gap_q      <= gap_d;
         gap_run_q  <= gap_run_d;
      end
   end

   assign rawData_o   = raw_q;
   assign rxValid_o   = valid_q;
   assign byteIdx_o   = idx_q;
   assign frameDone_o = done_q;
   assign frameErr_o  = err_q;
   assign resync_o    = err_q;
   assign errCnt_o    = errcnt_q;

endmodule
